// File: rtl/stage_id_pipe_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU op/select encodings, field widths.
package stage_id_pipe_pkg;

  localparam int INST_W = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,  ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4,  ALU_XOR = 4'd5, ALU_OR  = 4'd6, ALU_AND = 4'd7,
    ALU_SLL  = 4'd8,  ALU_SRL = 4'd9, ALU_SRA = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    SEL_NOP = 3'd0, SEL_ARITH = 3'd1, SEL_LOGIC = 3'd2, SEL_SHIFT = 3'd3, SEL_JUMP = 3'd4
  } alu_sel_e;

  // alt selects SUB/SRA (instruction bit 30)
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_sel_e sel_of(input alu_op_e op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU: return SEL_ARITH;
      ALU_XOR, ALU_OR, ALU_AND:            return SEL_LOGIC;
      ALU_SLL, ALU_SRL, ALU_SRA:           return SEL_SHIFT;
      default:                             return SEL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/stage_id_pipe_if.sv
// Bundle of fetch-side, regfile, forwarding and result signals for stage_id_pipe.
// ID_BRANCH_EN adds br_taken / br_target.
interface stage_id_pipe_if import stage_id_pipe_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NFWD = 2
) ();
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [XLEN-1:0]        pc;
  logic [INST_W-1:0]      inst;
  logic                   re1, re2;
  logic [REG_AW-1:0]      reg_addr1, reg_addr2;
  logic [XLEN-1:0]        reg_data1, reg_data2;
  logic [NFWD-1:0]        fwd_we;
  logic [NFWD-1:0]        fwd_is_load;
  logic [NFWD*REG_AW-1:0] fwd_waddr;
  logic [NFWD*XLEN-1:0]   fwd_wdata;
  logic                   out_valid;
  logic                   out_ready;
  alu_op_e                aluop;
  alu_sel_e               alusel;
  logic [XLEN-1:0]        opv1, opv2;
  logic [REG_AW-1:0]      reg_waddr;
  logic                   we;
  logic                   illegal;
`ifdef ID_BRANCH_EN
  logic                   br_taken;
  logic [XLEN-1:0]        br_target;
`endif

  modport slave (
    input  flush, in_valid, pc, inst, reg_data1, reg_data2,
           fwd_we, fwd_is_load, fwd_waddr, fwd_wdata, out_ready,
    output in_ready, re1, re2, reg_addr1, reg_addr2,
           out_valid, aluop, alusel, opv1, opv2, reg_waddr, we, illegal
`ifdef ID_BRANCH_EN
    , output br_taken, br_target
`endif
  );

  modport master (
    output flush, in_valid, pc, inst, reg_data1, reg_data2,
           fwd_we, fwd_is_load, fwd_waddr, fwd_wdata, out_ready,
    input  in_ready, re1, re2, reg_addr1, reg_addr2,
           out_valid, aluop, alusel, opv1, opv2, reg_waddr, we, illegal
`ifdef ID_BRANCH_EN
    , input br_taken, br_target
`endif
  );
endinterface

// File: rtl/stage_id_pipe_id_decoder.sv
// Combinational RV32I integer decoder; unknown opcode/funct yields illegal with NOP and no reads/writes.
// ID_BRANCH_EN adds JAL/JALR/BRANCH decode.
module id_decoder import stage_id_pipe_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [INST_W-1:0] inst,
  input  logic [XLEN-1:0]   pc,
  output alu_op_e           aluop,
  output alu_sel_e          alusel,
  output logic              re1, re2,
  output logic [REG_AW-1:0] addr1, addr2, waddr,
  output logic [XLEN-1:0]   imm1, imm2,
  output logic              we,
  output logic              illegal
`ifdef ID_BRANCH_EN
  , output logic            link,
  output logic              is_branch, is_jump, is_jalr,
  output logic [XLEN-1:0]   br_off
`endif
);
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] i_imm, u_imm, shamt;
  logic            legal, ctl;

  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign i_imm = XLEN'($signed(inst[31:20]));
  assign u_imm = XLEN'($signed({inst[31:12], 12'h000}));
  assign shamt = XLEN'(inst[24:20]);

  always_comb begin
    aluop = ALU_NOP;
    re1   = 1'b0;
    re2   = 1'b0;
    we    = 1'b0;
    imm1  = '0;
    imm2  = '0;
    legal = 1'b0;
    ctl   = 1'b0;
`ifdef ID_BRANCH_EN
    link      = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_jalr   = 1'b0;
    br_off    = '0;
`endif
    case (inst[6:0])
      OPC_OP_IMM: begin
        re1   = 1'b1;
        we    = 1'b1;
        aluop = f3_to_alu(f3, (f3 == 3'b101) && inst[30]);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm2  = shamt;
          legal = (f7 == 7'h00) || (f3 == 3'b101 && f7 == 7'h20);
        end else begin
          imm2  = i_imm;
          legal = 1'b1;
        end
      end
      OPC_OP: begin
        re1   = 1'b1;
        re2   = 1'b1;
        we    = 1'b1;
        aluop = f3_to_alu(f3, inst[30]);
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      end
      OPC_LUI, OPC_AUIPC: begin
        we    = 1'b1;
        aluop = ALU_ADD;
        imm1  = (inst[6:0] == OPC_AUIPC) ? pc : '0;
        imm2  = u_imm;
        legal = 1'b1;
      end
`ifdef ID_BRANCH_EN
      OPC_JAL, OPC_JALR: begin
        // result path computes the link pc+4; target goes through br_off
        we      = 1'b1;
        aluop   = ALU_ADD;
        link    = 1'b1;
        is_jump = 1'b1;
        ctl     = 1'b1;
        imm1    = pc;
        imm2    = XLEN'(4);
        if (inst[6:0] == OPC_JALR) begin
          re1     = 1'b1;
          is_jalr = 1'b1;
          br_off  = i_imm;
          legal   = (f3 == 3'b000);
        end else begin
          br_off = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
          legal  = 1'b1;
        end
      end
      OPC_BRANCH: begin
        re1       = 1'b1;
        re2       = 1'b1;
        is_branch = 1'b1;
        ctl       = 1'b1;
        br_off    = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        legal     = (f3 != 3'b010) && (f3 != 3'b011);
      end
`endif
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      aluop = ALU_NOP;
      re1   = 1'b0;
      re2   = 1'b0;
      we    = 1'b0;
      ctl   = 1'b0;
`ifdef ID_BRANCH_EN
      link      = 1'b0;
      is_branch = 1'b0;
      is_jump   = 1'b0;
      is_jalr   = 1'b0;
`endif
    end
  end

  assign illegal = !legal;
  assign alusel  = ctl ? SEL_JUMP : sel_of(aluop);
  assign addr1   = re1 ? inst[19:15] : '0;
  assign addr2   = re2 ? inst[24:20] : '0;
  assign waddr   = we  ? inst[11:7]  : '0;
endmodule

// File: rtl/stage_id_pipe.sv
// ID stage: decode + operand forwarding into a 1-cycle output register; valid/ready, holds on !out_ready,
// stalls on load-use, flush drops in-flight result. ID_BRANCH_EN adds branch/jump resolution.
module stage_id_pipe import stage_id_pipe_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NFWD = 2
) (
  input logic             clk,
  input logic             rst,
  stage_id_pipe_if.slave  bus
);
  alu_op_e           dec_aluop;
  alu_sel_e          dec_alusel;
  logic              dec_re1, dec_re2, dec_we, dec_illegal;
  logic [REG_AW-1:0] dec_addr1, dec_addr2, dec_waddr;
  logic [XLEN-1:0]   dec_imm1, dec_imm2;
  logic [XLEN-1:0]   src1, src2, opv1_n, opv2_n;
  logic              hazard, stall, accept;
`ifdef ID_BRANCH_EN
  logic              dec_link, dec_branch, dec_jump, dec_jalr, taken_n;
  logic [XLEN-1:0]   dec_br_off, jalr_sum, target_n;
`endif

  id_decoder #(.XLEN(XLEN)) u_dec (
    .inst(bus.inst), .pc(bus.pc),
    .aluop(dec_aluop), .alusel(dec_alusel),
    .re1(dec_re1), .re2(dec_re2),
    .addr1(dec_addr1), .addr2(dec_addr2), .waddr(dec_waddr),
    .imm1(dec_imm1), .imm2(dec_imm2),
    .we(dec_we), .illegal(dec_illegal)
`ifdef ID_BRANCH_EN
    , .link(dec_link), .is_branch(dec_branch), .is_jump(dec_jump),
    .is_jalr(dec_jalr), .br_off(dec_br_off)
`endif
  );

  assign bus.re1       = dec_re1;
  assign bus.re2       = dec_re2;
  assign bus.reg_addr1 = dec_addr1;
  assign bus.reg_addr2 = dec_addr2;

  // Descending scan so the lowest-index (youngest) matching source wins; x0 never forwards.
  always_comb begin
    src1   = (dec_addr1 == '0) ? '0 : bus.reg_data1;
    src2   = (dec_addr2 == '0) ? '0 : bus.reg_data2;
    hazard = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (bus.fwd_we[i] && (bus.fwd_waddr[i*REG_AW +: REG_AW] == dec_addr1) && (dec_addr1 != '0)) begin
        src1 = bus.fwd_wdata[i*XLEN +: XLEN];
        if (bus.fwd_is_load[i]) hazard = 1'b1;
      end
      if (bus.fwd_we[i] && (bus.fwd_waddr[i*REG_AW +: REG_AW] == dec_addr2) && (dec_addr2 != '0)) begin
        src2 = bus.fwd_wdata[i*XLEN +: XLEN];
        if (bus.fwd_is_load[i]) hazard = 1'b1;
      end
    end
  end

  always_comb begin
    opv1_n = dec_re1 ? src1 : dec_imm1;
    opv2_n = dec_re2 ? src2 : dec_imm2;
`ifdef ID_BRANCH_EN
    if (dec_link) opv1_n = dec_imm1;
`endif
  end

`ifdef ID_BRANCH_EN
  assign jalr_sum = src1 + dec_br_off;

  always_comb begin
    taken_n  = 1'b0;
    target_n = dec_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : bus.pc + dec_br_off;
    if (dec_jump) begin
      taken_n = 1'b1;
    end else if (dec_branch) begin
      case (bus.inst[14:12])
        3'b000:  taken_n = (src1 == src2);
        3'b001:  taken_n = (src1 != src2);
        3'b100:  taken_n = ($signed(src1) <  $signed(src2));
        3'b101:  taken_n = ($signed(src1) >= $signed(src2));
        3'b110:  taken_n = (src1 <  src2);
        3'b111:  taken_n = (src1 >= src2);
        default: taken_n = 1'b0;
      endcase
    end
  end
`endif

  assign stall        = bus.in_valid && hazard;
  assign bus.in_ready = !rst && !stall && !bus.flush && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.aluop     <= ALU_NOP;
      bus.alusel    <= SEL_NOP;
      bus.opv1      <= '0;
      bus.opv2      <= '0;
      bus.reg_waddr <= '0;
      bus.we        <= 1'b0;
      bus.illegal   <= 1'b0;
`ifdef ID_BRANCH_EN
      bus.br_taken  <= 1'b0;
      bus.br_target <= '0;
`endif
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.aluop     <= dec_aluop;
      bus.alusel    <= dec_alusel;
      bus.opv1      <= opv1_n;
      bus.opv2      <= opv2_n;
      bus.reg_waddr <= dec_waddr;
      bus.we        <= dec_we;
      bus.illegal   <= dec_illegal;
`ifdef ID_BRANCH_EN
      bus.br_taken  <= taken_n;
      bus.br_target <= target_n;
`endif
    end else if (bus.out_ready) begin
      // consumed with nothing new (idle or load-use stall): leave a bubble
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed bench for stage_id_pipe: reset, decode, forwarding, load-use, hold, flush, reset-during-hold.
// Branch checks are active when ID_BRANCH_EN is defined.
module tb_stage_id_pipe;
    import stage_id_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    stage_id_pipe_if #(.XLEN(32), .NFWD(2)) bus ();

    stage_id_pipe #(.XLEN(32), .NFWD(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        errors++;
        $error("FAIL timeout: wait expired before simulation finished");
        $finish;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.pc          = 32'h0;
        bus.inst        = 32'h0;
        bus.reg_data1   = 32'h0;
        bus.reg_data2   = 32'h0;
        bus.fwd_we      = 2'b00;
        bus.fwd_is_load = 2'b00;
        bus.fwd_waddr   = 10'h0;
        bus.fwd_wdata   = 64'h0;
        bus.out_ready   = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_aluop", bus.aluop, ALU_NOP);
        chk("rst_alusel", bus.alusel, SEL_NOP);
        chk("rst_opv1", bus.opv1, 0);
        chk("rst_opv2", bus.opv2, 0);
        chk("rst_waddr", bus.reg_waddr, 0);
        chk("rst_in_ready", bus.in_ready, 0);

        // ADDI x1,x0,-5 : x0 reads as zero whatever the regfile returns
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.inst      = enc_i(12'hFFB, 5'd0, 3'b000, 5'd1, 7'h13);
        bus.reg_data1 = 32'hDEAD_BEEF;
        #1;
        chk("addi_in_ready", bus.in_ready, 1);
        chk("addi_re1", bus.re1, 1);
        chk("addi_re2", bus.re2, 0);
        chk("addi_addr1", bus.reg_addr1, 0);
        tick();
        chk("addi_out_valid", bus.out_valid, 1);
        chk("addi_opv1", bus.opv1, 32'h0);
        chk("addi_opv2", bus.opv2, 32'hFFFF_FFFB);
        chk("addi_we", bus.we, 1);
        chk("addi_waddr", bus.reg_waddr, 1);
        chk("addi_aluop", bus.aluop, ALU_ADD);
        chk("addi_alusel", bus.alusel, SEL_ARITH);
        chk("addi_illegal", bus.illegal, 0);

        // ADD x3,x1,x2 : fwd0 x1=7 beats fwd1 x1=9; x2 from regfile
        bus.inst      = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        bus.reg_data1 = 32'd100;
        bus.reg_data2 = 32'd4;
        bus.fwd_we    = 2'b11;
        bus.fwd_waddr = {5'd1, 5'd1};
        bus.fwd_wdata = {32'd9, 32'd7};
        tick();
        chk("add_fwd0_opv1", bus.opv1, 7);
        chk("add_fwd_opv2", bus.opv2, 4);
        chk("add_waddr", bus.reg_waddr, 3);
        chk("add_aluop", bus.aluop, ALU_ADD);

        // only fwd1 enabled now
        bus.fwd_we = 2'b10;
        tick();
        chk("add_fwd1_opv1", bus.opv1, 9);
        chk("add_fwd1_valid", bus.out_valid, 1);

        // SRAI x9,x1,3
        bus.fwd_we    = 2'b00;
        bus.inst      = enc_i(12'h403, 5'd1, 3'b101, 5'd9, 7'h13);
        bus.reg_data1 = 32'h8000_0000;
        tick();
        chk("srai_opv1", bus.opv1, 32'h8000_0000);
        chk("srai_opv2", bus.opv2, 3);
        chk("srai_aluop", bus.aluop, ALU_SRA);
        chk("srai_alusel", bus.alusel, SEL_SHIFT);

        // LUI x7,0x12345
        bus.inst = enc_u(20'h12345, 5'd7, 7'h37);
        tick();
        chk("lui_opv1", bus.opv1, 0);
        chk("lui_opv2", bus.opv2, 32'h1234_5000);
        chk("lui_waddr", bus.reg_waddr, 7);

        // AUIPC x8,1 at pc 0x200
        bus.pc   = 32'h200;
        bus.inst = enc_u(20'h00001, 5'd8, 7'h17);
        tick();
        chk("auipc_opv1", bus.opv1, 32'h200);
        chk("auipc_opv2", bus.opv2, 32'h1000);
        chk("auipc_aluop", bus.aluop, ALU_ADD);

        // SLLI with funct7=0x20 is illegal
        bus.inst = enc_i(12'h401, 5'd1, 3'b001, 5'd2, 7'h13);
        tick();
        chk("badslli_illegal", bus.illegal, 1);
        chk("badslli_we", bus.we, 0);
        chk("badslli_aluop", bus.aluop, ALU_NOP);
        chk("badslli_alusel", bus.alusel, SEL_NOP);
        chk("badslli_valid", bus.out_valid, 1);

        // BEQ x1,x1,+16 at pc 0x100
        bus.pc        = 32'h100;
        bus.inst      = enc_b(13'd16, 5'd1, 5'd1, 3'b000);
        bus.reg_data1 = 32'd5;
        bus.reg_data2 = 32'd5;
        tick();
`ifdef ID_BRANCH_EN
        chk("beq_illegal", bus.illegal, 0);
        chk("beq_taken", bus.br_taken, 1);
        chk("beq_target", bus.br_target, 32'h110);
        chk("beq_we", bus.we, 0);
        // JALR x1,x2,5 at pc 0x300 with x2=0x1000
        bus.pc        = 32'h300;
        bus.inst      = enc_i(12'd5, 5'd2, 3'b000, 5'd1, 7'h67);
        bus.reg_data1 = 32'h1000;
        tick();
        chk("jalr_taken", bus.br_taken, 1);
        chk("jalr_target", bus.br_target, 32'h1004);
        chk("jalr_link_opv1", bus.opv1, 32'h300);
        chk("jalr_link_opv2", bus.opv2, 4);
        chk("jalr_waddr", bus.reg_waddr, 1);
`else
        chk("beq_illegal", bus.illegal, 1);
        chk("beq_we", bus.we, 0);
`endif

        // load-use: fwd0 loads x5, ORI x6,x5,1 must stall one cycle
        bus.inst        = enc_i(12'd1, 5'd5, 3'b110, 5'd6, 7'h13);
        bus.fwd_we      = 2'b01;
        bus.fwd_is_load = 2'b01;
        bus.fwd_waddr   = {5'd0, 5'd5};
        bus.fwd_wdata   = {32'd0, 32'h10};
        #1;
        chk("lu_stall_in_ready", bus.in_ready, 0);
        tick();
        chk("lu_bubble", bus.out_valid, 0);
        bus.fwd_is_load = 2'b00;
        #1;
        chk("lu_release_in_ready", bus.in_ready, 1);
        tick();
        chk("lu_valid", bus.out_valid, 1);
        chk("lu_opv1", bus.opv1, 32'h10);
        chk("lu_opv2", bus.opv2, 1);
        chk("lu_aluop", bus.aluop, ALU_OR);
        chk("lu_alusel", bus.alusel, SEL_LOGIC);
        chk("lu_waddr", bus.reg_waddr, 6);

        // hold: SUB x4,x1,x2 then out_ready low for 3 cycles
        bus.fwd_we    = 2'b00;
        bus.inst      = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
        bus.reg_data1 = 32'd20;
        bus.reg_data2 = 32'd3;
        tick();
        chk("sub_aluop", bus.aluop, ALU_SUB);
        bus.out_ready = 1'b0;
        bus.inst      = enc_i(12'd9, 5'd1, 3'b000, 5'd10, 7'h13);
        bus.reg_data1 = 32'd77;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_in_ready", bus.in_ready, 0);
            tick();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_opv1", bus.opv1, 20);
            chk("hold_opv2", bus.opv2, 3);
            chk("hold_aluop", bus.aluop, ALU_SUB);
            chk("hold_waddr", bus.reg_waddr, 4);
        end

        // reset while a result is held
        rst = 1'b1;
        #1;
        chk("rsthold_in_ready", bus.in_ready, 0);
        tick();
        chk("rsthold_valid", bus.out_valid, 0);
        chk("rsthold_aluop", bus.aluop, ALU_NOP);
        chk("rsthold_opv1", bus.opv1, 0);
        rst = 1'b0;

        // flush in the cycle an accept would happen
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        tick();
        chk("flush_valid", bus.out_valid, 0);
        bus.flush = 1'b0;
        tick();
        chk("post_flush_valid", bus.out_valid, 1);
        chk("post_flush_opv2", bus.opv2, 9);
        // flush drops a held result
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        tick();
        chk("flush_held_valid", bus.out_valid, 0);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("idle_valid", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_id_pipe.md
STAGE_ID_PIPE -- requirements
Module: stage_id_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and register width.
REQ-002 SHALL have parameter NFWD, default 2, meaning forwarding source count; index 0 is the youngest stage (EX).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port flush, input, 1, meaning discard the in-flight and held instruction.
REQ-006 SHALL have port in_valid, input, 1, meaning pc and inst are valid.
REQ-007 SHALL have port in_ready, output, 1, meaning an instruction is accepted this cycle.
REQ-008 SHALL have port pc, input, XLEN, meaning the instruction address.
REQ-009 SHALL have port inst, input, 32, meaning the instruction word.
REQ-010 SHALL have ports re1 and re2, output, 1 each, meaning register-file read enables.
REQ-011 SHALL have ports reg_addr1 and reg_addr2, output, 5 each, meaning register-file read addresses.
REQ-012 SHALL have ports reg_data1 and reg_data2, input, XLEN each, meaning register-file read data.
REQ-013 SHALL have ports fwd_we, fwd_is_load, fwd_waddr and fwd_wdata, input, NFWD, NFWD, NFWD*5 and NFWD*XLEN bits, meaning per-source write enable, load flag, destination and data.
REQ-014 SHALL have port out_valid, output, 1, meaning the registered decode result is valid.
REQ-015 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-016 SHALL have registered outputs aluop (AluOpBus), alusel (AluSelBus), opv1 and opv2 (XLEN each), reg_waddr (5), we (1) and illegal (1).

Function
REQ-017 SHALL decode OP_IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), OP (the same ten R-type operations), LUI and AUIPC.
REQ-018 SHALL sign-extend the I-immediate to XLEN, use the zero-extended shamt inst[24:20] for shifts, and use {inst[31:12], 12'h0} for LUI and AUIPC.
REQ-019 SHALL, for AUIPC, set opv1 = pc and opv2 = U-immediate, with aluop ADD.
REQ-020 SHALL, for any other opcode or funct combination, set illegal=1, we=0 and aluop/alusel to NOP.
REQ-021 SHALL resolve each operand in this priority order: lowest-index source i with fwd_we[i] and a matching waddr; otherwise regfile data; otherwise the immediate when the read enable is 0.
REQ-022 SHALL never forward to address x0; any read of x0 yields 0.
REQ-023 SHALL raise a load-use stall when a source i has fwd_we[i], fwd_is_load[i] and a waddr equal to a nonzero, enabled read address.
REQ-024 SHALL drive in_ready combinationally as !stall && !flush && (!out_valid || out_ready).
REQ-025 SHALL load the output register when in_valid && in_ready.
REQ-026 SHALL clear out_valid when stalled and out_ready=1, which inserts a bubble.
REQ-027 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-028 SHALL clear out_valid on the edge after flush=1; flush takes priority over a simultaneous accept or stall.
REQ-029 SHALL have a latency of exactly 1 cycle from acceptance to out_valid.

Reset
REQ-030 SHALL, on rst=1 at a rising edge, set out_valid=0, we=0, illegal=0, aluop/alusel=NOP, opv1=opv2=0 and reg_waddr=0.
REQ-031 SHALL let rst override flush, stall and accept, and SHALL discard any instruction that was mid-acceptance.
REQ-032 SHALL hold in_ready=0 while rst=1.

Configuration
REQ-033 SHALL, with macro ID_BRANCH_EN defined, decode JAL, JALR and BRANCH.
REQ-034 SHALL, with ID_BRANCH_EN defined, resolve branches using the forwarded operands and add registered outputs br_taken (1) and br_target (XLEN), valid with out_valid.
REQ-035 SHALL, with ID_BRANCH_EN defined, write link = pc+4 to rd for JAL and JALR, and clear bit 0 of the JALR target.
REQ-036 SHALL, without ID_BRANCH_EN, omit br_taken and br_target and flag those opcodes as illegal.

Structure
REQ-037 SHALL take opcode constants, AluOp and AluSel encodings, and bus widths from the shared defines package; no local redefinition is allowed.
REQ-038 SHALL place decode in sub-module id_decoder, which is purely combinational: inst and pc in; aluop, alusel, re, addr, imm, we and illegal out.

Verification
REQ-039 SHALL verify: ADDI x1,x0,-5 with out_ready=1 gives, one cycle later, opv2=32'hFFFFFFFB, we=1 and reg_waddr=1.
REQ-040 SHALL verify: ADD x3,x1,x2 with fwd0 writing x1=7 and fwd1 writing x1=9 and x2=4 gives opv1=7 and opv2=4.
REQ-041 SHALL verify: fwd0 as a load to x5 with inst ORI x6,x5,1 gives in_ready=0 and one bubble, then acceptance once the load flag drops.
REQ-042 SHALL verify: out_ready=0 for 3 cycles holds all outputs unchanged and in_ready=0.
REQ-043 SHALL verify: flush asserted in the same cycle as accept gives out_valid=0 on the next edge.
REQ-044 SHALL verify: rst pulsed while a result is held gives out_valid=0 next cycle; with ID_BRANCH_EN, BEQ x1,x1,+16 at pc 0x100 gives br_taken=1 and br_target=0x110.
